// File: rtl/fft_mag_stream_if.sv
// Stream bundle for fft_mag_stream: complex-bin input, magnitude output and frame-peak report.
interface fft_mag_stream_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned IW    = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_real;
  logic signed [IN_W-1:0]  in_imag;
  logic [1:0]              mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_mag;
  logic [IW-1:0]           out_idx;
  logic                    out_last;
  logic                    peak_valid;
  logic [OUT_W-1:0]        peak_mag;
  logic [IW-1:0]           peak_idx;

  modport master (
    output in_valid, in_real, in_imag, mode, out_ready,
    input  in_ready, out_valid, out_mag, out_idx, out_last, peak_valid, peak_mag, peak_idx
  );

  modport slave (
    input  in_valid, in_real, in_imag, mode, out_ready,
    output in_ready, out_valid, out_mag, out_idx, out_last, peak_valid, peak_mag, peak_idx
  );
endinterface

// File: rtl/fft_mag_stream.sv
// Streaming alpha-max-plus-beta-min magnitude (3-stage, globally stalled) with per-frame peak tracking.
module fft_mag_stream #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned NBINS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_mag_stream_if.slave   bus
);
  localparam int unsigned IW = (NBINS > 2) ? $clog2(NBINS) : 1;
  localparam int unsigned SW = IN_W + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

  function automatic logic [IN_W-1:0] abs_val(input logic [IN_W-1:0] x);
    return (x ^ {IN_W{x[IN_W-1]}}) + IN_W'(x[IN_W-1]);
  endfunction

  logic             w_en, w_acc, w_hs;
  logic [1:0]       w_mode;
  logic [IW-1:0]    r_in_cnt;
  logic [1:0]       r_mode_q;

  logic             r_v1, r_v2, r_v3;
  logic [IN_W-1:0]  r_are, r_aim, r_max, r_min;
  logic [IW-1:0]    r_idx1, r_idx2, r_idx;
  logic [1:0]       r_mode1, r_mode2;
  logic [OUT_W-1:0] r_mag;
  logic             r_last;

  logic [SW-1:0]    w_mx, w_mn, w_sum;
  logic [OUT_W-1:0] w_mag;
  logic             w_unused;

  logic             w_take;
  logic [OUT_W-1:0] w_pk_mag;
  logic [IW-1:0]    w_pk_idx;
  logic [OUT_W-1:0] r_run_mag, r_peak_mag;
  logic [IW-1:0]    r_run_idx, r_peak_idx;
  logic             r_pvalid;

  assign w_en   = !r_v3 || bus.out_ready;
  assign w_acc  = bus.in_valid && w_en;
  assign w_hs   = r_v3 && bus.out_ready;
  assign w_mode = (r_in_cnt == '0) ? bus.mode : r_mode_q;

  // Stage-3 combine in IN_W+1 bits, then saturate and keep the top OUT_W bits.
  assign w_mx = SW'(r_max);
  assign w_mn = SW'(r_min);
  always_comb begin
    w_sum = '0;
    case (r_mode2)
      2'd0:    w_sum = w_mx + (w_mn >> 1);
      2'd1:    w_sum = w_mx + (w_mn >> 2);
      2'd2:    w_sum = (w_mx - (w_mx >> 4)) + ((w_mn >> 1) - (w_mn >> 5));
      default: w_sum = w_mx + w_mn;
    endcase
  end
  assign w_mag    = w_sum[IN_W] ? {OUT_W{1'b1}} : w_sum[IN_W-1 -: OUT_W];
  assign w_unused = ^w_sum;

  // Bin 0 always reloads the running peak; later bins replace it only on a strict increase.
  assign w_take   = (r_idx == '0) || (r_mag > r_run_mag);
  assign w_pk_mag = w_take ? r_mag : r_run_mag;
  assign w_pk_idx = w_take ? r_idx : r_run_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_cnt   <= '0;
      r_mode_q   <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_are      <= '0;
      r_aim      <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_idx1     <= '0;
      r_idx2     <= '0;
      r_idx      <= '0;
      r_mode1    <= '0;
      r_mode2    <= '0;
      r_mag      <= '0;
      r_last     <= 1'b0;
      r_run_mag  <= '0;
      r_run_idx  <= '0;
      r_peak_mag <= '0;
      r_peak_idx <= '0;
      r_pvalid   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_in_cnt <= (r_in_cnt == LAST_IDX) ? '0 : r_in_cnt + IW'(1);
        if (r_in_cnt == '0) r_mode_q <= bus.mode;
      end
      if (w_en) begin
        r_v1 <= w_acc;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        if (w_acc) begin
          r_are   <= abs_val(bus.in_real);
          r_aim   <= abs_val(bus.in_imag);
          r_idx1  <= r_in_cnt;
          r_mode1 <= w_mode;
        end
        if (r_v1) begin
          r_max   <= (r_are > r_aim) ? r_are : r_aim;
          r_min   <= (r_are > r_aim) ? r_aim : r_are;
          r_idx2  <= r_idx1;
          r_mode2 <= r_mode1;
        end
        if (r_v2) begin
          r_mag  <= w_mag;
          r_idx  <= r_idx2;
          r_last <= (r_idx2 == LAST_IDX);
        end
      end
      r_pvalid <= w_hs && r_last;
      if (w_hs) begin
        r_run_mag <= w_pk_mag;
        r_run_idx <= w_pk_idx;
        if (r_last) begin
          r_peak_mag <= w_pk_mag;
          r_peak_idx <= w_pk_idx;
        end
      end
    end
  end

  assign bus.in_ready   = w_en;
  assign bus.out_valid  = r_v3;
  assign bus.out_mag    = r_mag;
  assign bus.out_idx    = r_idx;
  assign bus.out_last   = r_last;
  assign bus.peak_valid = r_pvalid;
  assign bus.peak_mag   = r_peak_mag;
  assign bus.peak_idx   = r_peak_idx;
endmodule

// File: tb/tb_fft_mag_stream.sv
// Directed bench for fft_mag_stream (IN_W=16, OUT_W=8, NBINS=4) with hand-computed expectations.
module tb_fft_mag_stream;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  fft_mag_stream_if #(.IN_W(16), .OUT_W(8), .IW(2)) bus ();

  fft_mag_stream #(.IN_W(16), .OUT_W(8), .NBINS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] f_re [4];
  logic signed [15:0] f_im [4];
  logic [1:0]         f_md [4];
  logic [7:0]         c_mag [4];
  logic [1:0]         c_idx [4];
  logic               c_last [4];
  int                 c_n, c_first, pk_cnt, pk_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic signed [15:0] re, input logic signed [15:0] im,
                         input logic [1:0] m0, input logic [1:0] mr);
    for (int i = 0; i < 4; i++) begin
      f_re[i] = re;
      f_im[i] = im;
      f_md[i] = (i == 0) ? m0 : mr;
    end
  endtask

  // Streams the four f_* bins back to back with out_ready high and records what comes out.
  task automatic run_frame();
    c_n = 0; c_first = -1; pk_cnt = 0; pk_cyc = -1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        bus.in_valid = 1'b1;
        bus.in_real  = f_re[c];
        bus.in_imag  = f_im[c];
        bus.mode     = f_md[c];
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.out_valid) begin
        if (c_n == 0) c_first = c;
        if (c_n < 4) begin
          c_mag[c_n]  = bus.out_mag;
          c_idx[c_n]  = bus.out_idx;
          c_last[c_n] = bus.out_last;
        end
        c_n++;
      end
      if (bus.peak_valid) begin
        pk_cnt++;
        pk_cyc = c;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [7:0] pm, input logic [1:0] pi);
    chk({tag, "_count"},   32'(c_n), 32'd4);
    chk({tag, "_latency"}, 32'(c_first), 32'd2);
    chk({tag, "_mag0"},    32'(c_mag[0]), 32'(e0));
    chk({tag, "_mag1"},    32'(c_mag[1]), 32'(e1));
    chk({tag, "_mag2"},    32'(c_mag[2]), 32'(e2));
    chk({tag, "_mag3"},    32'(c_mag[3]), 32'(e3));
    chk({tag, "_idx"},     32'({c_idx[3], c_idx[2], c_idx[1], c_idx[0]}), 32'h0000_00E4);
    chk({tag, "_last"},    32'({c_last[3], c_last[2], c_last[1], c_last[0]}), 32'b1000);
    chk({tag, "_pk_cnt"},  32'(pk_cnt), 32'd1);
    chk({tag, "_pk_cyc"},  32'(pk_cyc), 32'd6);
    chk({tag, "_pk_mag"},  32'(bus.peak_mag), 32'(pm));
    chk({tag, "_pk_idx"},  32'(bus.peak_idx), 32'(pi));
  endtask

  int        pat [6] = '{1, 0, 0, 1, 0, 1};
  int        sent, rcv;
  logic      acc, held, pv_seen, ov_seen;
  logic [7:0] h_mag;
  logic [1:0] h_idx;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.mode      = 2'd0;
    bus.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_mag",    32'(bus.out_mag), 32'd0);
    chk("rst_out_last",   32'(bus.out_last), 32'd0);
    chk("rst_peak_valid", 32'(bus.peak_valid), 32'd0);
    chk("rst_peak_mag",   32'(bus.peak_mag), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",   32'(bus.in_ready), 32'd1);

    // (3000, -4000) in each mode, mode set at bin 0 of each frame
    set_all(16'sd3000, -16'sd4000, 2'd0, 2'd0); run_frame();
    check_frame("mode0", 8'h15, 8'h15, 8'h15, 8'h15, 8'h15, 2'd0);
    set_all(16'sd3000, -16'sd4000, 2'd1, 2'd1); run_frame();
    check_frame("mode1", 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 2'd0);
    set_all(16'sd3000, -16'sd4000, 2'd2, 2'd2); run_frame();
    check_frame("mode2", 8'h14, 8'h14, 8'h14, 8'h14, 8'h14, 2'd0);
    set_all(16'sd3000, -16'sd4000, 2'd3, 2'd3); run_frame();
    check_frame("mode3", 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 2'd0);

    // Mode latched at bin 0 only
    set_all(16'sd3000, -16'sd4000, 2'd3, 2'd0); run_frame();
    check_frame("latch_l1", 8'h1B, 8'h1B, 8'h1B, 8'h1B, 8'h1B, 2'd0);
    set_all(16'sd3000, -16'sd4000, 2'd0, 2'd3); run_frame();
    check_frame("latch_m0", 8'h15, 8'h15, 8'h15, 8'h15, 8'h15, 2'd0);

    // Extremes in mode 0
    set_all(16'sd0, 16'sd0, 2'd0, 2'd0);
    f_re[0] = -16'sd32768; f_im[0] = -16'sd32768;
    f_re[2] = 16'sd32767;
    f_re[3] = 16'sd3000;   f_im[3] = -16'sd4000;
    run_frame();
    check_frame("extreme_m0", 8'hC0, 8'h00, 8'h7F, 8'h15, 8'hC0, 2'd0);

    // Most-negative inputs saturate in L1 mode
    set_all(-16'sd32768, -16'sd32768, 2'd3, 2'd3); run_frame();
    check_frame("extreme_m3", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 2'd0);

    // Peak: 0x10, 0x40, 0x40, 0x20 -> tie keeps bin 1; bin 0 reloads after the 0xFF frame
    set_all(16'sd0, 16'sd0, 2'd0, 2'd0);
    f_re[0] = 16'sh1000; f_re[1] = 16'sh4000; f_im[2] = 16'sh4000; f_re[3] = 16'sh2000;
    run_frame();
    check_frame("peak", 8'h10, 8'h40, 8'h40, 8'h20, 8'h40, 2'd1);

    // Backpressure: 8 bins with magnitude (k+1)*8 while out_ready follows 1,0,0,1,0,1...
    sent = 0; rcv = 0; held = 1'b0; h_mag = '0; h_idx = '0;
    bus.mode = 2'd0;
    for (int c = 0; c < 80 && rcv < 8; c++) begin
      bus.out_ready = (pat[c % 6] != 0);
      bus.in_valid  = (sent < 8);
      bus.in_real   = 16'((sent + 1) * 16'h0800);
      bus.in_imag   = '0;
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (held) begin
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_mag",   32'(bus.out_mag), 32'(h_mag));
        chk("bp_hold_idx",   32'(bus.out_idx), 32'(h_idx));
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_mag",  32'(bus.out_mag), 32'((rcv + 1) * 8));
        chk("bp_idx",  32'(bus.out_idx), 32'(rcv % 4));
        chk("bp_last", 32'(bus.out_last), 32'((rcv % 4) == 3));
        rcv++;
      end
      held  = bus.out_valid && !bus.out_ready;
      h_mag = bus.out_mag;
      h_idx = bus.out_idx;
      tick();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_sent",       32'(sent), 32'd8);
    chk("bp_received",   32'(rcv), 32'd8);
    chk("bp_peak_valid", 32'(bus.peak_valid), 32'd1);
    chk("bp_peak_mag",   32'(bus.peak_mag), 32'h40);
    chk("bp_peak_idx",   32'(bus.peak_idx), 32'd3);
    tick();
    chk("bp_peak_pulse", 32'(bus.peak_valid), 32'd0);

    // Reset after two accepted bins
    bus.in_valid = 1'b1; bus.in_real = 16'sh4000; bus.in_imag = '0; bus.mode = 2'd0;
    tick(); tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_out_valid",  32'(bus.out_valid), 32'd0);
    chk("mid_out_mag",    32'(bus.out_mag), 32'd0);
    chk("mid_out_idx",    32'(bus.out_idx), 32'd0);
    chk("mid_out_last",   32'(bus.out_last), 32'd0);
    chk("mid_peak_mag",   32'(bus.peak_mag), 32'd0);
    chk("mid_peak_idx",   32'(bus.peak_idx), 32'd0);
    chk("mid_in_ready",   32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    pv_seen = 1'b0; ov_seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      pv_seen |= bus.peak_valid;
      ov_seen |= bus.out_valid;
    end
    chk("mid_no_peak",  32'(pv_seen), 32'd0);
    chk("mid_no_out",   32'(ov_seen), 32'd0);

    set_all(16'sd0, 16'sd0, 2'd0, 2'd0);
    f_re[0] = 16'sh1000; f_re[1] = 16'sh4000; f_im[2] = 16'sh4000; f_re[3] = 16'sh2000;
    run_frame();
    check_frame("post_rst", 8'h10, 8'h40, 8'h40, 8'h20, 8'h40, 2'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
